// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the quasi-cyclic LDPC syndrome checker: circulant size,
// circulant-row type, checker FSM states and a syndrome popcount helper.
package qc_ldpc_pkg;

    localparam int Z     = 88;
    localparam int CNT_W = 7;

    typedef logic [Z-1:0] circ_row_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_H = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_t;

    // 88 set bits at most, so 7 bits always hold the count.
    function automatic logic [6:0] popcount_row(input circ_row_t row);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < Z; i++) begin
            cnt = cnt + 7'(row[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/circulant_rotator_88bit.sv
// Loadable 88-bit right-rotate register holding the current circulant row;
// load has priority over rotate.
module circulant_rotator_88bit
    import qc_ldpc_pkg::*;
(
    input  logic      clk,
    input  logic      clear,
    input  logic      load_i,
    input  logic      rot_en_i,
    input  circ_row_t row_i,
    output circ_row_t row_o
);

    circ_row_t row_q;
    circ_row_t row_d;

    always_comb begin
        row_d = row_q;
        if (load_i) begin
            row_d = row_i;
        end else if (rot_en_i) begin
            row_d = {row_q[0], row_q[Z-1:1]};
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/qc_syndrome_checker_88bit.sv
// Serial QC-LDPC syndrome checker: one circulant row per block, one code bit per
// accepted cycle. Optional synd_weight output enabled by defining SYND_WEIGHT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; syndrome / codeword_ok held
// ST_LOAD_H | h_req high, waiting for the circulant row of block blk_idx
// ST_ACCUM  | bit_ready high, folding 88 code bits into the syndrome
// ST_DONE   | one-cycle done pulse, results final
module qc_syndrome_checker_88bit
    import qc_ldpc_pkg::*;
#(
    parameter int NB = 4,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    input  logic [Z-1:0]  h_in,
    input  logic          h_valid,
    output logic          h_req,
    input  logic          code_bit,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic [BW-1:0] blk_idx,
    output logic          busy,
    output logic          done,
    output logic [Z-1:0]  syndrome,
`ifdef SYND_WEIGHT_EN
    output logic [6:0]    synd_weight,
`endif
    output logic          codeword_ok
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Z - 1);
    localparam logic [BW-1:0]    LAST_BLK = BW'(NB - 1);

    chk_state_t       state_q, state_d;
    circ_row_t        syn_q, syn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    blk_q, blk_d;
    logic             ok_q, ok_d;
    logic             rot_load;
    logic             rot_en;
    circ_row_t        rot_row;

    circulant_rotator_88bit u_rot (
        .clk      (clk),
        .clear    (clear),
        .load_i   (rot_load),
        .rot_en_i (rot_en),
        .row_i    (h_in),
        .row_o    (rot_row)
    );

    // codeword_ok is captured on the transition into ST_DONE so it is already
    // valid while done is high.
    always_comb begin
        state_d   = state_q;
        syn_d     = syn_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        ok_d      = ok_q;
        rot_load  = 1'b0;
        rot_en    = 1'b0;
        h_req     = 1'b0;
        bit_ready = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    syn_d   = '0;
                    ok_d    = 1'b0;
                    blk_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_LOAD_H;
                end
            end
            ST_LOAD_H: begin
                h_req = 1'b1;
                if (h_valid) begin
                    rot_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    syn_d  = syn_q ^ (rot_row & {Z{code_bit}});
                    rot_en = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (blk_q == LAST_BLK) begin
                            ok_d    = (syn_d == '0);
                            state_d = ST_DONE;
                        end else begin
                            blk_d   = blk_q + BW'(1);
                            state_d = ST_LOAD_H;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            syn_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            syn_q   <= syn_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ok_q    <= ok_d;
        end
    end

`ifdef SYND_WEIGHT_EN
    logic [6:0] weight_q, weight_d;

    always_comb begin
        weight_d = weight_q;
        if (state_q == ST_IDLE && start) begin
            weight_d = '0;
        end else if (state_q == ST_ACCUM && state_d == ST_DONE) begin
            weight_d = popcount_row(syn_d);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            weight_q <= '0;
        end else begin
            weight_q <= weight_d;
        end
    end

    assign synd_weight = weight_q;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign blk_idx     = blk_q;
    assign syndrome    = syn_q;
    assign codeword_ok = ok_q;

endmodule

// File: tb/tb_qc_syndrome_checker_88bit.sv
// Self-checking bench for qc_syndrome_checker_88bit: directed codewords plus
// random-gap codewords checked against a rotation-sum syndrome model.
module tb_qc_syndrome_checker_88bit;

    localparam int NB  = 4;
    localparam int Z   = 88;
    localparam int TOT = NB * Z;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [Z-1:0]  h_in;
    logic          h_valid;
    logic          h_req;
    logic          code_bit;
    logic          bit_valid;
    logic          bit_ready;
    logic [1:0]    blk_idx;
    logic          busy;
    logic          done;
    logic [Z-1:0]  syndrome;
    logic          codeword_ok;
`ifdef SYND_WEIGHT_EN
    logic [6:0]    synd_weight;
`endif

    always #5 clk = ~clk;

    qc_syndrome_checker_88bit #(.NB(NB)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .h_in        (h_in),
        .h_valid     (h_valid),
        .h_req       (h_req),
        .code_bit    (code_bit),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .blk_idx     (blk_idx),
        .busy        (busy),
        .done        (done),
        .syndrome    (syndrome),
`ifdef SYND_WEIGHT_EN
        .synd_weight (synd_weight),
`endif
        .codeword_ok (codeword_ok)
    );

    logic [Z-1:0] h_tab [NB];
    bit           bits  [TOT];
    logic [Z-1:0] exp_syn;
    bit           armed;
    bit           hold_valid;
    int           n_total;
    int           n_pass;
    int           n_done_seen;

    task automatic chk(input string name, input logic [Z-1:0] act, input logic [Z-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Reference: bit k of block j contributes H_j rotated right by k.
    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] h, input int k);
        if (k == 0) return h;
        return (h >> k) | (h << (Z - k));
    endfunction

    function automatic logic [Z-1:0] ref_syn();
        logic [Z-1:0] s;
        s = '0;
        for (int j = 0; j < NB; j++)
            for (int k = 0; k < Z; k++)
                if (bits[j*Z + k]) s = s ^ rotr(h_tab[j], k);
        return s;
    endfunction

    task automatic zero_tables();
        for (int j = 0; j < NB; j++) h_tab[j] = '0;
        for (int n = 0; n < TOT; n++) bits[n] = 1'b0;
    endtask

    task automatic random_tables();
        logic [95:0] tmp;
        for (int j = 0; j < NB; j++) begin
            tmp = {$urandom(), $urandom(), $urandom()};
            h_tab[j] = tmp[Z-1:0];
        end
        for (int n = 0; n < TOT; n++) bits[n] = 1'($urandom_range(1));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_done"},        done,        0);
        chk({tag, "_h_req"},       h_req,       0);
        chk({tag, "_bit_ready"},   bit_ready,   0);
        chk({tag, "_blk_idx"},     blk_idx,     0);
        chk({tag, "_syndrome"},    syndrome,    0);
        chk({tag, "_codeword_ok"}, codeword_ok, 0);
`ifdef SYND_WEIGHT_EN
        chk({tag, "_synd_weight"}, synd_weight, 0);
`endif
    endtask

    // Compare process: handshake exclusivity every cycle, results at done,
    // and result stability while idle afterwards.
    always @(negedge clk) begin
        if (!clear) begin
            chk("no_req_ready_overlap", h_req & bit_ready, 0);
            if (done) begin
                n_done_seen++;
                chk("done_expected", armed, 1);
                if (armed) begin
                    chk("syndrome_at_done", syndrome, exp_syn);
                    chk("ok_at_done", codeword_ok, (exp_syn == '0));
`ifdef SYND_WEIGHT_EN
                    chk("weight_at_done", synd_weight, $countones(exp_syn));
`endif
                    armed      = 1'b0;
                    hold_valid = 1'b1;
                end
            end else if (hold_valid && !busy) begin
                chk("syndrome_held", syndrome, exp_syn);
                chk("ok_held", codeword_ok, (exp_syn == '0));
            end
        end
    end

    task automatic run_cw(input int gap_pct, input int abort_n, input bit start_in_done,
                          input string tag);
        int hj, n, cyc, done_before;
        bit got;
        exp_syn    = ref_syn();
        hold_valid = 1'b0;
        armed      = (abort_n < 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hj = 0; n = 0; cyc = 0;
        while (!(hj == NB && n == TOT) && cyc < 5000) begin
            if (abort_n >= 0 && n == abort_n) break;
            h_in      = (hj < NB) ? h_tab[hj] : '0;
            h_valid   = (hj < NB) && ($urandom_range(99) >= gap_pct);
            code_bit  = (n < TOT) ? bits[n] : 1'b0;
            bit_valid = (n < TOT) && ($urandom_range(99) >= gap_pct);
            start     = (gap_pct > 0) && ($urandom_range(9) == 0);
            @(negedge clk);
            if (h_req && h_valid) begin
                chk({tag, "_blk_idx_at_load"}, blk_idx, hj);
                hj++;
            end
            if (bit_ready && bit_valid) n++;
            @(posedge clk); #1;
            cyc++;
        end
        h_valid = 1'b0; bit_valid = 1'b0; start = 1'b0; code_bit = 1'b0;
        if (cyc >= 5000) begin
            fail_now({tag, "_transfer_timeout"});
        end else if (abort_n < 0) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            if (!got) fail_now({tag, "_done_timeout"});
            else if (start_in_done) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                chk({tag, "_start_in_done_ignored"}, busy, 0);
            end
        end else begin
            @(negedge clk);
            chk({tag, "_abort_blk_idx"}, blk_idx, 2);
            chk({tag, "_abort_busy"}, busy, 1);
            done_before = n_done_seen;
            @(posedge clk); #1;
            clear = 1'b1;
            #1;
            check_reset({tag, "_clear_async"});
            @(negedge clk);
            check_reset({tag, "_clear_held"});
            @(posedge clk); #1;
            clear = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            chk({tag, "_no_done_after_clear"}, n_done_seen - done_before, 0);
            chk({tag, "_idle_after_clear"}, busy, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_done_seen = 0;
        armed = 1'b0; hold_valid = 1'b0;
        clear = 1'b1; start = 1'b0; h_in = '0; h_valid = 1'b0;
        code_bit = 1'b0; bit_valid = 1'b0;
        zero_tables();
        #12;
        check_reset("por");
        @(posedge clk); #1;
        clear = 1'b0;
        @(posedge clk); #1;

        // All-zero codeword, unit circulants.
        zero_tables();
        for (int j = 0; j < NB; j++) h_tab[j] = 88'h1;
        run_cw(0, -1, 1'b0, "zero_cw");
        chk("zero_cw_syndrome_lit", syndrome, 88'h0);
        chk("zero_cw_ok_lit", codeword_ok, 1);

        // Single bit at block 0 position 1 lands on syndrome bit 87.
        zero_tables();
        for (int j = 0; j < NB; j++) h_tab[j] = 88'h1;
        bits[1] = 1'b1;
        run_cw(0, -1, 1'b1, "single_bit");
        chk("single_bit_syndrome_lit", syndrome, {1'b1, 87'b0});
        chk("single_bit_ok_lit", codeword_ok, 0);

        // Equal contributions from blocks 0 and 1 cancel.
        zero_tables();
        h_tab[0] = 88'h20; h_tab[1] = 88'h20;
        bits[0] = 1'b1; bits[Z] = 1'b1;
        run_cw(0, -1, 1'b0, "cancel");
        chk("cancel_syndrome_lit", syndrome, 88'h0);
        chk("cancel_ok_lit", codeword_ok, 1);

        // Weight-4 syndrome.
        zero_tables();
        h_tab[0] = 88'hF;
        bits[0] = 1'b1;
        run_cw(0, -1, 1'b0, "weight4");
        chk("weight4_syndrome_lit", syndrome, 88'hF);
        chk("weight4_ok_lit", codeword_ok, 0);
`ifdef SYND_WEIGHT_EN
        chk("weight4_weight_lit", synd_weight, 4);
`endif

        for (int r = 0; r < 3; r++) begin
            random_tables();
            run_cw(30, -1, 1'b0, $sformatf("rand%0d", r));
        end

        random_tables();
        run_cw(25, 2*Z + 40, 1'b0, "abort");
        random_tables();
        run_cw(20, -1, 1'b0, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qc_syndrome_checker_88bit.md
QC_SYNDROME_CHECKER_88BIT -- requirements
Module: qc_syndrome_checker_88bit

Interface
REQ-001 Parameter NB, default 4, number of 88-bit circulant column blocks per codeword (codeword length NB*88).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin checking one codeword; sampled only in IDLE.
REQ-005 h_in  input  88  first row of the current parity-check circulant H_j.
REQ-006 h_valid  input  1  h_in valid; accepted when h_req and h_valid are both high.
REQ-007 h_req  output  1  requests first row of circulant for block blk_idx.
REQ-008 code_bit  input  1  received codeword bit, serial, block 0 bit 0 first.
REQ-009 bit_valid  input  1  code_bit valid; accepted when bit_ready and bit_valid are both high.
REQ-010 bit_ready  output  1  checker accepts a codeword bit this cycle.
REQ-011 blk_idx  output  $clog2(NB)  index of the circulant block being processed.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse, syndrome final.
REQ-014 syndrome  output  88  accumulated syndrome, held until next accepted start.
REQ-015 codeword_ok  output  1  high when the held syndrome is all-zero; updated with done.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_H, ACCUM and DONE.
REQ-017 IDLE: start high -> clear syndrome and codeword_ok, blk_idx=0, go to LOAD_H next cycle.
REQ-018 LOAD_H: h_req=1; on h_valid, load h_in into the rotator, bit counter=0, go to ACCUM; otherwise wait indefinitely.
REQ-019 ACCUM: bit_ready=1; each accepted bit performs syndrome <= syndrome XOR (rot AND {88{code_bit}}), then rot <= {rot[0], rot[87:1]}, counter++.
REQ-020 Bit k of a block (k=0..87) SHALL therefore use h_in rotated right by k; cycles with bit_valid low change nothing.
REQ-021 On acceptance of bit 87: blk_idx < NB-1 -> blk_idx++, go to LOAD_H; blk_idx = NB-1 -> go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, codeword_ok = (syndrome == 0), go to IDLE.
REQ-023 h_req and bit_ready SHALL never be high in the same cycle; neither is high in IDLE or DONE.
REQ-024 start outside IDLE SHALL be ignored; start in the DONE cycle is also ignored.
REQ-025 syndrome and codeword_ok SHALL remain stable from DONE until the next accepted start.

Reset
REQ-026 clear SHALL force IDLE, syndrome=0, rot=0, counter=0, blk_idx=0, codeword_ok=0, done=0, h_req=0, bit_ready=0, busy=0, at any time.
REQ-027 clear during LOAD_H or ACCUM SHALL abandon the codeword with no done pulse; the next start begins from block 0.

Configuration
REQ-028 With SYND_WEIGHT_EN defined, an extra output synd_weight (7 bits, popcount of syndrome) SHALL be registered in DONE, held like syndrome and cleared to 0 by clear or start.
REQ-029 Without SYND_WEIGHT_EN, the synd_weight port and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Shared package qc_ldpc_pkg SHALL hold Z=88, the circulant-row typedef (88-bit vector) and the FSM state enum.
REQ-031 The 88-bit loadable right-rotate register SHALL be one sub-module, circulant_rotator_88bit (load, enable-rotate, parallel out).

Verification
REQ-032 NB=4, all h_in=88'h1, all 352 code bits 0 -> done after the last bit, syndrome=0, codeword_ok=1.
REQ-033 h0=88'h1, only block 0 bit 1 = 1 -> syndrome has only bit 87 set, codeword_ok=0.
REQ-034 h0=h1=88'h20, block 0 bit 0 and block 1 bit 0 = 1 -> contributions cancel, syndrome=0, codeword_ok=1.
REQ-035 Random gaps on bit_valid and h_valid, random codeword -> syndrome matches the reference model; h_req/bit_ready never overlap.
REQ-036 clear asserted mid-ACCUM in block 2 -> all outputs at reset values, no done; a following full codeword checks correctly.
REQ-037 SYND_WEIGHT_EN defined, h0=88'hF, block 0 bit 0 = 1, rest 0 -> synd_weight=4 at done.
